// File: rtl/hiscore_ram_arbiter.sv
// Hands the single-port game RAM from the CPU to the hiscore engine: halt the CPU, let the bus settle, grant, then release.
// Optional build macro HISCORE_ARB_VBLANK_GATE_EN adds a vblank input that gates the start of a halt to a vblank rising edge.
module hiscore_ram_arbiter #(
    parameter int          ADDRESSWIDTH  = 10,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] HALT_TIMEOUT  = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
`ifdef HISCORE_ARB_VBLANK_GATE_EN
    input  logic                    vblank,
`endif
    input  logic                    hs_pause,
    input  logic [ADDRESSWIDTH-1:0] hs_address,
    input  logic [7:0]              hs_data,
    input  logic                    hs_write,
    output logic [7:0]              hs_din,
    output logic                    hs_grant,
    input  logic [ADDRESSWIDTH-1:0] cpu_address,
    input  logic [7:0]              cpu_data,
    input  logic                    cpu_write,
    output logic                    cpu_halt,
    input  logic                    cpu_idle,
    output logic [ADDRESSWIDTH-1:0] ram_address,
    output logic [7:0]              ram_data,
    output logic                    ram_write,
    input  logic [7:0]              ram_q,
    output logic                    forced_grant,
    output logic                    write_dropped
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HALT_REQ = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_GRANT    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    logic [2:0]              state_r;
    logic [2:0]              state_next_s;
    logic [15:0]             timer_r;
    logic [15:0]             timer_next_s;
    logic [7:0]              settle_r;
    logic [7:0]              settle_next_s;
    logic                    force_set_s;
    logic                    start_req_s;
    logic                    grant_sel_s;
    logic                    cpu_halt_r;
    logic                    hs_grant_r;
    logic [ADDRESSWIDTH-1:0] ram_address_r;
    logic [7:0]              ram_data_r;
    logic                    ram_write_r;
    logic [7:0]              hs_din_r;
    logic                    forced_grant_r;
    logic                    write_dropped_r;

`ifdef HISCORE_ARB_VBLANK_GATE_EN
    logic vblank_q_r;

    // Delayed vblank for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q_r <= 1'b0;
        end else begin
            vblank_q_r <= vblank;
        end
    end

    assign start_req_s = hs_pause & vblank & ~vblank_q_r;
`else
    assign start_req_s = hs_pause;
`endif

    // Next-state, timer and settle-counter logic; a dropped request always wins.
    always_comb begin
        state_next_s  = state_r;
        timer_next_s  = timer_r;
        settle_next_s = settle_r;
        force_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_req_s) begin
                    state_next_s = ST_HALT_REQ;
                    timer_next_s = HALT_TIMEOUT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HALT_REQ: begin
                if (!hs_pause) begin
                    state_next_s = ST_RELEASE;
                end else if (cpu_idle) begin
                    state_next_s  = ST_SETTLE;
                    settle_next_s = SETTLE_LOAD;
                end else if (timer_r <= 16'd1) begin
                    // Timer reaches zero on this decrement: grant anyway.
                    timer_next_s  = 16'd0;
                    force_set_s   = 1'b1;
                    state_next_s  = ST_SETTLE;
                    settle_next_s = SETTLE_LOAD;
                end else begin
                    timer_next_s = timer_r - 16'd1;
                end
            end
            ST_SETTLE: begin
                if (!hs_pause) begin
                    state_next_s = ST_RELEASE;
                end else if (settle_r == 8'd0) begin
                    state_next_s = ST_GRANT;
                end else begin
                    settle_next_s = settle_r - 8'd1;
                end
            end
            ST_GRANT: begin
                if (!hs_pause) begin
                    state_next_s = ST_RELEASE;
                end else begin
                    state_next_s = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Mux select follows the next state so entry routes hs_* and exit routes cpu_*.
    assign grant_sel_s = (state_next_s == ST_GRANT);

    // State, registered handshake outputs, RAM mux, read capture and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            timer_r         <= 16'd0;
            settle_r        <= 8'd0;
            cpu_halt_r      <= 1'b0;
            hs_grant_r      <= 1'b0;
            ram_address_r   <= '0;
            ram_data_r      <= 8'd0;
            ram_write_r     <= 1'b0;
            hs_din_r        <= 8'd0;
            forced_grant_r  <= 1'b0;
            write_dropped_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            timer_r         <= timer_next_s;
            settle_r        <= settle_next_s;
            cpu_halt_r      <= (state_next_s != ST_IDLE);
            hs_grant_r      <= grant_sel_s;
            ram_address_r   <= grant_sel_s ? hs_address : cpu_address;
            ram_data_r      <= grant_sel_s ? hs_data : cpu_data;
            ram_write_r     <= grant_sel_s ? hs_write : cpu_write;
            if (hs_grant_r) begin
                hs_din_r <= ram_q;
            end
            forced_grant_r  <= forced_grant_r | force_set_s;
            write_dropped_r <= write_dropped_r | (hs_write & ~grant_sel_s);
        end
    end

    assign cpu_halt      = cpu_halt_r;
    assign hs_grant      = hs_grant_r;
    assign ram_address   = ram_address_r;
    assign ram_data      = ram_data_r;
    assign ram_write     = ram_write_r;
    assign hs_din        = hs_din_r;
    assign forced_grant  = forced_grant_r;
    assign write_dropped = write_dropped_r;

endmodule
